if_fetch_stage: RTL

Instruction-fetch front end of the 4-stage pipeline: owns the program counter, drives the synchronous instruction memory, and loads the IF/ID pipeline register consumed by the decode/datapath stage. Handles downstream stall, branch redirect with flush, halt, and a delivered-instruction counter. It replaces the free-running PC and the bare IF/ID latch with one stall-aware stage.

---
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, synchronous instruction-memory
// request, and IF/ID pipeline register with stall, redirect/flush, halt and
// a count of delivered instructions.
module if_fetch_stage #(
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned ISIZE    = 32,
    parameter int unsigned PC_STEP  = 1,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [ISIZE-1:0]  imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc,
    input  logic              halt,
    output logic [ISIZE-1:0]  id_inst,
    output logic [AWIDTH-1:0] id_pc,
    output logic              id_valid,
    output logic [15:0]       fetch_count
);

    localparam int unsigned CWIDTH = 16;
    localparam logic [AWIDTH-1:0] STEP = AWIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e              state_q,       state_d;
    logic [AWIDTH-1:0]   pc_q,          pc_d;
    logic [AWIDTH-1:0]   req_pc_q,      req_pc_d;
    logic                req_valid_q,   req_valid_d;
    logic [ISIZE-1:0]    id_inst_q,     id_inst_d;
    logic [AWIDTH-1:0]   id_pc_q,       id_pc_d;
    logic                id_valid_q,    id_valid_d;
    logic [CWIDTH-1:0]   fetch_count_q, fetch_count_d;

    // Memory address: reset vector, redirect target, replay of the stalled
    // request so its data is presented again, or the next sequential pc.
    always_comb begin
        imem_addr = pc_q;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = req_pc_q;
        end
    end

    // Next-state logic: redirect flushes, stall freezes, otherwise advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_valid_d   = req_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        if (redirect) begin
            req_pc_d    = redirect_pc;
            req_valid_d = 1'b1;
            pc_d        = redirect_pc + STEP;
            id_valid_d  = 1'b0;
            state_d     = ST_RUN;
        end else if (!stall) begin
            id_inst_d     = imem_rdata;
            id_pc_d       = req_pc_q;
            id_valid_d    = req_valid_q;
            fetch_count_d = fetch_count_q + CWIDTH'(req_valid_q);
            unique case (state_q)
                ST_BOOT: begin
                    req_pc_d    = pc_q;
                    req_valid_d = 1'b1;
                    pc_d        = pc_q + STEP;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    if (halt) begin
                        req_valid_d = 1'b0;
                        state_d     = ST_HALT;
                    end else begin
                        req_pc_d    = pc_q;
                        req_valid_d = 1'b1;
                        pc_d        = pc_q + STEP;
                    end
                end
                ST_HALT: begin
                    req_valid_d = 1'b0;
                end
                default: begin
                    req_valid_d = 1'b0;
                    state_d     = ST_BOOT;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset discards any in-flight fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            id_inst_q     <= '0;
            id_pc_q       <= '0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
